// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the uP pipeline. Owns the program counter,
// drives the synchronous instruction ROM address, applies jump / branch /
// stall redirection and registers the IF/ID pair. Wrong-path instructions
// are turned into NOP bubbles here.
//
// Ports
//   Clock, Reset      : single clock, synchronous active-high reset
//   iStall            : hold fetch and IF/ID
//   iJmpEnable/iJmpDir: unconditional jump and its absolute target
//   iBranchTaken, iBranchPC, iBranchOffset : taken branch, its PC and
//                       signed displacement (target = PC + 1 + offset)
//   oRomAddr          : combinational next-fetch address to the ROM
//   iRomInstr         : ROM data for the address presented on the last edge
//   oInstID/oPCID/oValidID : IF/ID instruction, its PC, valid (0 = bubble)
module fetch_stage #(
    parameter int                  ADDR_W    = 10,
    parameter int                  INSTR_W   = 16,
    parameter int                  BOFS_W    = 6,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStall,
    input  logic               iJmpEnable,
    input  logic [ADDR_W-1:0]  iJmpDir,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchPC,
    input  logic [BOFS_W-1:0]  iBranchOffset,
    output logic [ADDR_W-1:0]  oRomAddr,
    input  logic [INSTR_W-1:0] iRomInstr,
    output logic [INSTR_W-1:0] oInstID,
    output logic [ADDR_W-1:0]  oPCID,
    output logic               oValidID
);

    // Address whose instruction is on iRomInstr this cycle.
    logic [ADDR_W-1:0]  pc_f_q, pc_f_d;
    logic [INSTR_W-1:0] inst_id_q, inst_id_d;
    logic [ADDR_W-1:0]  pc_id_q, pc_id_d;
    logic               valid_id_q, valid_id_d;

    logic               redirect;
    logic [ADDR_W-1:0]  branch_ofs_sext;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  rom_addr;

    assign redirect        = iJmpEnable | iBranchTaken;
    assign branch_ofs_sext = {{(ADDR_W-BOFS_W){iBranchOffset[BOFS_W-1]}}, iBranchOffset};
    // Sum wraps modulo 2^ADDR_W by truncation.
    assign branch_target   = iBranchPC + ADDR_W'(1) + branch_ofs_sext;
    assign redirect_target = iJmpEnable ? iJmpDir : branch_target;

    // Next fetch address. During a stall the current address is replayed so
    // the synchronous ROM keeps presenting the held instruction.
    always_comb begin
        rom_addr = pc_f_q + ADDR_W'(1);
        if (Reset) begin
            rom_addr = RESET_PC;
        end else if (redirect) begin
            rom_addr = redirect_target;
        end else if (iStall) begin
            rom_addr = pc_f_q;
        end
    end

    // IF/ID next state. A redirect discards the wrong-path ROM word and
    // overrides any concurrent stall.
    always_comb begin
        pc_f_d     = rom_addr;
        inst_id_d  = iRomInstr;
        pc_id_d    = pc_f_q;
        valid_id_d = 1'b1;
        if (redirect) begin
            inst_id_d  = NOP_INSTR;
            pc_id_d    = '0;
            valid_id_d = 1'b0;
        end else if (iStall) begin
            inst_id_d  = inst_id_q;
            pc_id_d    = pc_id_q;
            valid_id_d = valid_id_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_f_q     <= RESET_PC;
            inst_id_q  <= NOP_INSTR;
            pc_id_q    <= '0;
            valid_id_q <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            inst_id_q  <= inst_id_d;
            pc_id_q    <= pc_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    assign oRomAddr = rom_addr;
    assign oInstID  = inst_id_q;
    assign oPCID    = pc_id_q;
    assign oValidID = valid_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, jmp, br;
    logic [9:0]  jdir, bpc;
    logic [5:0]  bofs;
    logic [9:0]  rom_addr;
    logic [15:0] rom_instr;
    logic [15:0] inst_id;
    logic [9:0]  pc_id;
    logic        valid_id;

    // Second instance starting at 1022 to exercise PC wrap.
    logic        rst_w;
    logic [9:0]  rom_addr_w;
    logic [15:0] rom_instr_w;
    logic [15:0] inst_id_w;
    logic [9:0]  pc_id_w;
    logic        valid_id_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .Clock(clk), .Reset(rst), .iStall(stall),
        .iJmpEnable(jmp), .iJmpDir(jdir),
        .iBranchTaken(br), .iBranchPC(bpc), .iBranchOffset(bofs),
        .oRomAddr(rom_addr), .iRomInstr(rom_instr),
        .oInstID(inst_id), .oPCID(pc_id), .oValidID(valid_id)
    );

    fetch_stage #(.RESET_PC(10'd1022)) u_dut_wrap (
        .Clock(clk), .Reset(rst_w), .iStall(1'b0),
        .iJmpEnable(1'b0), .iJmpDir(10'd0),
        .iBranchTaken(1'b0), .iBranchPC(10'd0), .iBranchOffset(6'd0),
        .oRomAddr(rom_addr_w), .iRomInstr(rom_instr_w),
        .oInstID(inst_id_w), .oPCID(pc_id_w), .oValidID(valid_id_w)
    );

    // Synchronous ROM, mem[i] = 16'h1000 + i.
    always @(posedge clk) begin
        rom_instr   <= 16'h1000 + {6'd0, rom_addr};
        rom_instr_w <= 16'h1000 + {6'd0, rom_addr_w};
    end

    typedef struct {
        logic       rst, stall, jmp, br;
        logic [9:0] jdir, bpc;
        logic [5:0] bofs;
        logic [9:0] eaddr;   // oRomAddr during the cycle
        logic       ev;      // IF/ID after the edge
        logic [9:0] epc;
        logic [15:0] eins;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    // Wrap instance expectations for the first vectors (reset held 2 cycles).
    localparam int N_W = 7;
    logic [9:0]  w_addr [N_W] = '{10'd1022, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
    logic        w_v    [N_W] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [9:0]  w_pc   [N_W] = '{10'd0, 10'd0, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2};
    logic [15:0] w_ins  [N_W] = '{16'h0000, 16'h0000, 16'h13FE, 16'h13FF, 16'h1000, 16'h1001, 16'h1002};

    task automatic add(input logic r, input logic s, input logic j, input logic [9:0] jd,
                       input logic b, input logic [9:0] bp, input logic [5:0] bo,
                       input logic [9:0] ea, input logic ev, input logic [9:0] ep,
                       input logic [15:0] ei);
        vec_t v;
        v.rst = r; v.stall = s; v.jmp = j; v.jdir = jd; v.br = b; v.bpc = bp; v.bofs = bo;
        v.eaddr = ea; v.ev = ev; v.epc = ep; v.eins = ei;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int k);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // Directed vectors:  rst stall jmp jdir br bpc bofs | addr v pc instr
    initial begin
        add(1,0,0,0,   0,0,0,      10'd0,   0, 10'd0,   16'h0000);
        add(1,0,0,0,   0,0,0,      10'd0,   0, 10'd0,   16'h0000);
        add(0,0,0,0,   0,0,0,      10'd1,   1, 10'd0,   16'h1000);
        add(0,0,0,0,   0,0,0,      10'd2,   1, 10'd1,   16'h1001);
        add(0,0,0,0,   0,0,0,      10'd3,   1, 10'd2,   16'h1002);
        add(0,0,0,0,   0,0,0,      10'd4,   1, 10'd3,   16'h1003);
        add(0,0,0,0,   0,0,0,      10'd5,   1, 10'd4,   16'h1004);
        add(0,0,1,300, 0,0,0,      10'd300, 0, 10'd0,   16'h0000);  // jump
        add(0,0,0,0,   0,0,0,      10'd301, 1, 10'd300, 16'h112C);
        add(0,0,0,0,   0,0,0,      10'd302, 1, 10'd301, 16'h112D);
        add(0,0,0,0,   1,40,6'b111100, 10'd37, 0, 10'd0, 16'h0000); // 40+1-4
        add(0,0,0,0,   0,0,0,      10'd38,  1, 10'd37,  16'h1025);
        add(0,0,0,0,   1,40,6'b011111, 10'd72, 0, 10'd0, 16'h0000); // 40+1+31
        add(0,0,0,0,   0,0,0,      10'd73,  1, 10'd72,  16'h1048);
        add(0,0,0,0,   1,1020,6'd5, 10'd2,  0, 10'd0,   16'h0000);  // wraps
        add(0,0,0,0,   0,0,0,      10'd3,   1, 10'd2,   16'h1002);
        add(0,0,1,10,  0,0,0,      10'd10,  0, 10'd0,   16'h0000);
        add(0,0,0,0,   0,0,0,      10'd11,  1, 10'd10,  16'h100A);
        add(0,1,0,0,   0,0,0,      10'd11,  1, 10'd10,  16'h100A);  // stall x3
        add(0,1,0,0,   0,0,0,      10'd11,  1, 10'd10,  16'h100A);
        add(0,1,0,0,   0,0,0,      10'd11,  1, 10'd10,  16'h100A);
        add(0,0,0,0,   0,0,0,      10'd12,  1, 10'd11,  16'h100B);
        add(0,0,0,0,   0,0,0,      10'd13,  1, 10'd12,  16'h100C);
        add(0,1,1,100, 1,49,6'd0,  10'd100, 0, 10'd0,   16'h0000);  // all high
        add(0,0,0,0,   0,0,0,      10'd101, 1, 10'd100, 16'h1064);
        add(0,1,0,0,   0,0,0,      10'd101, 1, 10'd100, 16'h1064);
        add(1,1,0,0,   0,0,0,      10'd0,   0, 10'd0,   16'h0000);  // reset in stall
        add(0,0,0,0,   0,0,0,      10'd1,   1, 10'd0,   16'h1000);
        add(0,0,0,0,   0,0,0,      10'd2,   1, 10'd1,   16'h1001);
        add(1,0,1,500, 0,0,0,      10'd0,   0, 10'd0,   16'h0000);  // reset beats jump
        add(0,0,0,0,   0,0,0,      10'd1,   1, 10'd0,   16'h1000);
    end

    // Driver
    initial begin
        rst = 1'b1; rst_w = 1'b1; stall = 0; jmp = 0; br = 0; jdir = 0; bpc = 0; bofs = 0;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;   stall = vecs[i].stall;
            jmp   = vecs[i].jmp;   jdir  = vecs[i].jdir;
            br    = vecs[i].br;    bpc   = vecs[i].bpc;
            bofs  = vecs[i].bofs;
            rst_w = (i < 2);
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        rst = 0; stall = 0; jmp = 0; br = 0;
    end

    // Monitor / scoreboard
    initial begin
        vec_t e;
        int   n;
        #1;
        n = vecs.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout vec %0d: got empty scoreboard expected entry", k);
            end else begin
                e = sb.pop_front();
                chk("rom_addr", {22'd0, rom_addr}, {22'd0, e.eaddr}, k);
                if (k < N_W) chk("wrap_rom_addr", {22'd0, rom_addr_w}, {22'd0, w_addr[k]}, k);
                @(posedge clk);
                #1;
                chk("valid_id", {31'd0, valid_id}, {31'd0, e.ev}, k);
                chk("pc_id",    {22'd0, pc_id},    {22'd0, e.epc}, k);
                chk("inst_id",  {16'd0, inst_id},  {16'd0, e.eins}, k);
                if (k < N_W) begin
                    chk("wrap_valid_id", {31'd0, valid_id_w}, {31'd0, w_v[k]}, k);
                    chk("wrap_pc_id",    {22'd0, pc_id_w},    {22'd0, w_pc[k]}, k);
                    chk("wrap_inst_id",  {16'd0, inst_id_w},  {16'd0, w_ins[k]}, k);
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the decode stage of the 5-stage `uP` pipeline. It owns the program counter, drives the address of the synchronous instruction ROM, applies jump, branch and stall redirection, and registers the IF/ID pipeline pair (instruction, PC, valid). This replaces the free-running PC and the bare IF/ID register in the core. Wrong-path instructions are squashed to NOP bubbles inside this block.

## Interface
Parameters:
- `ADDR_W`, 10: PC / ROM address width.
- `INSTR_W`, 16: instruction width.
- `BOFS_W`, 6: branch offset width, two's complement.
- `RESET_PC`, 0: first fetch address after reset.
- `NOP_INSTR`, 16'h0000: instruction injected on squash and reset.

Ports:
- `Clock`  in  1  single clock, all state on posedge.
- `Reset`  in  1  synchronous, active-high.
- `iStall`  in  1  hold fetch and IF/ID (hazard from decode/EX).
- `iJmpEnable`  in  1  unconditional jump resolved this cycle.
- `iJmpDir`  in  ADDR_W  absolute jump target.
- `iBranchTaken`  in  1  conditional branch resolved taken this cycle.
- `iBranchPC`  in  ADDR_W  PC of the branch instruction.
- `iBranchOffset`  in  BOFS_W  signed branch displacement.
- `oRomAddr`  out  ADDR_W  combinational next-fetch address to ROM `pc`.
- `iRomInstr`  in  INSTR_W  ROM `instr`, data for the address presented on the previous edge.
- `oInstID`  out  INSTR_W  IF/ID instruction.
- `oPCID`  out  ADDR_W  IF/ID PC of `oInstID`.
- `oValidID`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Internal register `rPCF`: address whose instruction is on `iRomInstr` this cycle.
- Redirect = `iJmpEnable | iBranchTaken`. Target = `iJmpDir` if `iJmpEnable`, else `iBranchPC + 1 + sext(iBranchOffset)`, truncated to ADDR_W (mod 2^ADDR_W).
- Priority: Reset > jump > branch > stall > sequential.
- `oRomAddr` (combinational): Reset → `RESET_PC`; redirect → target; `iStall` → `rPCF` (replay the same address so the synchronous ROM re-presents the held instruction); else `rPCF + 1` (1023 wraps to 0).
- `rPCF <= oRomAddr` every edge.
- IF/ID update: Reset or redirect → `oInstID <= NOP_INSTR`, `oPCID <= 0`, `oValidID <= 0`. `iStall` → hold all three. Else → `oInstID <= iRomInstr`, `oPCID <= rPCF`, `oValidID <= 1`.
- The instruction on `iRomInstr` during a redirect cycle is discarded. Squashing later stages is not done here; the instruction already in ID during a redirect is squashed by the ID/EX control.
- A redirect concurrent with `iStall` is taken and the stall is ignored for this block.

## Timing
- Reset values: `oInstID`=NOP_INSTR, `oPCID`=0, `oValidID`=0, `rPCF`=RESET_PC. `oRomAddr`=RESET_PC while Reset is high.
- The ROM latches `RESET_PC` on the reset edge. First cycle after reset (c0): `iRomInstr`=mem[RESET_PC], `oRomAddr`=RESET_PC+1. End of c0: IF/ID valid with PC=RESET_PC. Steady state delivers 1 instruction per cycle.
- Fetch-to-ID latency is 2 edges: address edge, then IF/ID edge.
- Redirect in cycle r: target on `oRomAddr` in r. `oValidID`=0 during r+1 (one bubble). IF/ID holds the target instruction with `oPCID`=target during r+2.
- Stall for k cycles: IF/ID and `rPCF` are frozen k cycles. The first non-stall edge loads the instruction at the held `rPCF`. No instruction is lost or duplicated.
- Reset asserted mid-stall or mid-redirect: the reset values apply on that edge, and fetch restarts from RESET_PC as above.

## Test plan
- Reset, ROM mem[i]=16'h1000+i, no stall/redirect → ID sees PC 0,1,2,… with `oInstID`=16'h1000+PC, `oValidID`=1 from 2nd post-reset edge; `oValidID`=0 before.
- Run from RESET_PC=1022 → `oPCID` sequence 1022,1023,0,1 with matching instructions (wrap).
- `iJmpEnable`=1, `iJmpDir`=10'd300 in cycle r while PC≈5 → `oRomAddr`=300 in r, bubble (`oValidID`=0, `oInstID`=NOP) in r+1, `oPCID`=300 in r+2, then 301.
- `iBranchTaken` with `iBranchPC`=40, `iBranchOffset`=6'b111100 (−4) → target 37. Same test with offset +31 → 72; `iBranchPC`=1020, offset +5 → 2 (wrap).
- `iStall` high 3 cycles while `oPCID`=10 → `oPCID`/`oInstID` hold at 10 for 3 cycles, `oRomAddr`=rPCF held; after release the sequence continues 11,12 with no gap or duplicate.
- `iJmpEnable`, `iBranchTaken`, `iStall` all high together (jump 100, branch target 50) → jump to 100 taken, bubble next cycle. Reset asserted during a stall → reset values on that edge, restart at RESET_PC.
